pe_dpctl_gen: RTL and testbench

PE_DPCTL_GEN -- requirements
Module: pe_dpctl_gen

---
 rtl/pe_dpctl_gen_if.sv | 60 ++++++
 rtl/pe_dpctl_gen.sv | 186 ++++++++++++++++++
 tb/tb_pe_dpctl_gen.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_dpctl_gen_if.sv
// Handshake, configuration and status bundle for the pe_dpctl_gen loop controller.
// o_error exists only when PE_DPCTL_ERR_EN is defined.
interface pe_dpctl_gen_if #(
    parameter int NDIM  = 5,
    parameter int IDXW  = 6,
    parameter int ADDRW = 8
) ();
    logic                    i_start;
    logic                    i_abort;
    logic                    i_stall;
    logic [NDIM*IDXW-1:0]    i_loop_size;
    logic [NDIM*ADDRW-1:0]   i_in_stride;
    logic [NDIM*ADDRW-1:0]   i_wt_stride;
    logic [ADDRW:0]          i_in_cnt;
    logic [ADDRW:0]          i_wt_cnt;

    logic                    Input_rdy;
    logic                    Input_ack;
    logic                    Weight_rdy;
    logic                    Weight_ack;
    logic                    MAIN_rdy;
    logic                    MAIN_ack;

    logic [ADDRW-1:0]        o_in_waddr;
    logic [ADDRW-1:0]        o_in_raddr;
    logic [ADDRW-1:0]        o_wt_waddr;
    logic [ADDRW-1:0]        o_wt_raddr;
    logic                    o_in_write;
    logic                    o_wt_write;
    logic                    o_read;
    logic                    o_last;
    logic                    o_busy;
    logic                    o_done;
    logic [NDIM*IDXW-1:0]    o_idx;
`ifdef PE_DPCTL_ERR_EN
    logic                    o_error;
`endif

    modport master (
`ifdef PE_DPCTL_ERR_EN
        input  o_error,
`endif
        output i_start, i_abort, i_stall, i_loop_size, i_in_stride, i_wt_stride,
        output i_in_cnt, i_wt_cnt, Input_rdy, Weight_rdy, MAIN_ack,
        input  Input_ack, Weight_ack, MAIN_rdy,
        input  o_in_waddr, o_in_raddr, o_wt_waddr, o_wt_raddr,
        input  o_in_write, o_wt_write, o_read, o_last, o_busy, o_done, o_idx
    );

    modport slave (
`ifdef PE_DPCTL_ERR_EN
        output o_error,
`endif
        input  i_start, i_abort, i_stall, i_loop_size, i_in_stride, i_wt_stride,
        input  i_in_cnt, i_wt_cnt, Input_rdy, Weight_rdy, MAIN_ack,
        output Input_ack, Weight_ack, MAIN_rdy,
        output o_in_waddr, o_in_raddr, o_wt_waddr, o_wt_raddr,
        output o_in_write, o_wt_write, o_read, o_last, o_busy, o_done, o_idx
    );
endinterface

// File: rtl/pe_dpctl_gen.sv
// Nested-loop datapath controller: fills input/weight pads and walks NDIM loop indices.
// Optional sticky protocol-error flag enabled by defining PE_DPCTL_ERR_EN.
module pe_dpctl_gen #(
    parameter int NDIM  = 5,
    parameter int IDXW  = 6,
    parameter int ADDRW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pe_dpctl_gen_if.slave bus
);

    typedef enum logic [2:0] {IDLE, INIT, WORK, STALL, DONE} state_t;

    state_t state, state_nxt;

    logic [IDXW-1:0]  size_q      [NDIM];
    logic [ADDRW-1:0] in_stride_q [NDIM];
    logic [ADDRW-1:0] wt_stride_q [NDIM];
    logic [IDXW-1:0]  idx_q       [NDIM];
    logic [IDXW-1:0]  idx_nxt     [NDIM];
    logic [ADDRW:0]   in_cnt_q, wt_cnt_q;
    logic [ADDRW:0]   in_wcnt, wt_wcnt;

    logic [ADDRW-1:0]     in_raddr, wt_raddr;
    logic [NDIM*IDXW-1:0] idx_flat;
    logic                 all_last, carry;
    logic                 in_ack, wt_ack, main_rdy, busy, done;
    logic                 in_xfer, wt_xfer, main_xfer, clr_cnt;

    // A programmed trip count of zero runs the loop once.
    function automatic logic [IDXW-1:0] clamp_size(input logic [IDXW-1:0] s);
        return (s == '0) ? IDXW'(1) : s;
    endfunction

    function automatic logic [ADDRW-1:0] mul_mod(input logic [IDXW-1:0]  a,
                                                 input logic [ADDRW-1:0] b);
        logic [IDXW+ADDRW-1:0] p;
        p = {{ADDRW{1'b0}}, a} * {{IDXW{1'b0}}, b};
        return p[ADDRW-1:0];
    endfunction

    // Read addresses and last-iteration detect from the registered indices
    always_comb begin
        in_raddr = '0;
        wt_raddr = '0;
        all_last = 1'b1;
        idx_flat = '0;
        for (int k = 0; k < NDIM; k++) begin
            in_raddr = in_raddr + mul_mod(idx_q[k], in_stride_q[k]);
            wt_raddr = wt_raddr + mul_mod(idx_q[k], wt_stride_q[k]);
            if (idx_q[k] != size_q[k] - IDXW'(1)) all_last = 1'b0;
            idx_flat[k*IDXW +: IDXW] = idx_q[k];
        end
    end

    always_comb begin
        carry = 1'b1;
        for (int k = 0; k < NDIM; k++) begin
            idx_nxt[k] = idx_q[k];
            if (carry) begin
                if (idx_q[k] == size_q[k] - IDXW'(1)) begin
                    idx_nxt[k] = '0;
                end else begin
                    idx_nxt[k] = idx_q[k] + IDXW'(1);
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ack    = 1'b0;
        wt_ack    = 1'b0;
        main_rdy  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_start) state_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                state_nxt = bus.i_abort ? IDLE : WORK;
            end
            WORK: begin
                busy     = 1'b1;
                in_ack   = in_wcnt < in_cnt_q;
                wt_ack   = wt_wcnt < wt_cnt_q;
                // A word written this cycle becomes readable next cycle.
                main_rdy = ({1'b0, in_raddr} < in_wcnt) && ({1'b0, wt_raddr} < wt_wcnt);
                if (bus.i_abort)                            state_nxt = IDLE;
                else if (bus.i_stall)                       state_nxt = STALL;
                else if (main_rdy && bus.MAIN_ack && all_last) state_nxt = DONE;
            end
            STALL: begin
                busy = 1'b1;
                if (bus.i_abort)       state_nxt = IDLE;
                else if (!bus.i_stall) state_nxt = WORK;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_xfer   = in_ack && bus.Input_rdy;
    assign wt_xfer   = wt_ack && bus.Weight_rdy;
    assign main_xfer = main_rdy && bus.MAIN_ack;
    assign clr_cnt   = ((state == WORK) || (state == STALL)) && bus.i_abort;

    // Configuration latch and progress counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NDIM; k++) begin
                size_q[k]      <= '0;
                in_stride_q[k] <= '0;
                wt_stride_q[k] <= '0;
                idx_q[k]       <= '0;
            end
            in_cnt_q <= '0;
            wt_cnt_q <= '0;
            in_wcnt  <= '0;
            wt_wcnt  <= '0;
        end else if (state == INIT) begin
            for (int k = 0; k < NDIM; k++) begin
                size_q[k]      <= clamp_size(bus.i_loop_size[k*IDXW +: IDXW]);
                in_stride_q[k] <= bus.i_in_stride[k*ADDRW +: ADDRW];
                wt_stride_q[k] <= bus.i_wt_stride[k*ADDRW +: ADDRW];
                idx_q[k]       <= '0;
            end
            in_cnt_q <= bus.i_in_cnt;
            wt_cnt_q <= bus.i_wt_cnt;
            in_wcnt  <= '0;
            wt_wcnt  <= '0;
        end else if (clr_cnt) begin
            for (int k = 0; k < NDIM; k++) idx_q[k] <= '0;
            in_wcnt <= '0;
            wt_wcnt <= '0;
        end else begin
            if (in_xfer) in_wcnt <= in_wcnt + (ADDRW+1)'(1);
            if (wt_xfer) wt_wcnt <= wt_wcnt + (ADDRW+1)'(1);
            if (main_xfer) begin
                for (int k = 0; k < NDIM; k++) idx_q[k] <= idx_nxt[k];
            end
        end
    end

`ifdef PE_DPCTL_ERR_EN
    logic err_q;

    // Entering INIT clears the flag even if a violation coincides.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                   err_q <= 1'b0;
        else if ((state == IDLE) && bus.i_start)     err_q <= 1'b0;
        else if ((bus.MAIN_ack && !main_rdy) ||
                 (bus.i_start && (state != IDLE)))   err_q <= 1'b1;
    end

    assign bus.o_error = err_q;
`endif

    assign bus.Input_ack  = in_ack;
    assign bus.Weight_ack = wt_ack;
    assign bus.MAIN_rdy   = main_rdy;
    assign bus.o_in_write = in_xfer;
    assign bus.o_wt_write = wt_xfer;
    assign bus.o_read     = main_xfer;
    assign bus.o_in_waddr = in_wcnt[ADDRW-1:0];
    assign bus.o_wt_waddr = wt_wcnt[ADDRW-1:0];
    assign bus.o_in_raddr = in_raddr;
    assign bus.o_wt_raddr = wt_raddr;
    assign bus.o_idx      = idx_flat;
    assign bus.o_last     = ((state == WORK) || (state == STALL)) && all_last;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;

endmodule

// File: tb/tb_pe_dpctl_gen.sv
// Bench for pe_dpctl_gen: per-cycle comparison against a job-level reference model
// (flattened read list plus word counts), directed scenarios and random jobs.
module tb_pe_dpctl_gen;
    localparam int NDIM  = 3;
    localparam int IDXW  = 6;
    localparam int ADDRW = 8;
    localparam int P_IDLE = 0, P_INIT = 1, P_WORK = 2, P_STALL = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_dpctl_gen_if #(.NDIM(NDIM), .IDXW(IDXW), .ADDRW(ADDRW)) bus ();
    pe_dpctl_gen #(.NDIM(NDIM), .IDXW(IDXW), .ADDRW(ADDRW)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus));

    int checks = 0, errors = 0;
    int phase, n_in, n_wt, n_read, total, cfg_in_cnt, cfg_wt_cnt, max_in, max_wt;
    int cfg_size[3], cfg_is[3], cfg_ws[3];
    logic [ADDRW-1:0]     exp_ira[$], exp_wra[$];
    logic [NDIM*IDXW-1:0] exp_idx[$];
    int cyc, reads_seen, dones, first_in, first_mrdy, last_read_cyc, done_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_model();
        n_in = 0; n_wt = 0; n_read = 0;
    endtask

    task automatic inputs_low();
        bus.i_start = 0; bus.i_abort = 0; bus.i_stall = 0;
        bus.Input_rdy = 0; bus.Weight_rdy = 0; bus.MAIN_ack = 0;
    endtask

    // Expected read sequence: plain nested loops, dim 0 innermost.
    task automatic set_cfg(input bit auto_cnt);
        int s[3];
        int a, w;
        logic [NDIM*IDXW-1:0] v;
        exp_ira.delete(); exp_wra.delete(); exp_idx.delete();
        for (int k = 0; k < 3; k++) s[k] = (cfg_size[k] == 0) ? 1 : cfg_size[k];
        max_in = 0; max_wt = 0;
        for (int i2 = 0; i2 < s[2]; i2++)
            for (int i1 = 0; i1 < s[1]; i1++)
                for (int i0 = 0; i0 < s[0]; i0++) begin
                    a = (i0*cfg_is[0] + i1*cfg_is[1] + i2*cfg_is[2]) % 256;
                    w = (i0*cfg_ws[0] + i1*cfg_ws[1] + i2*cfg_ws[2]) % 256;
                    if (a > max_in) max_in = a;
                    if (w > max_wt) max_wt = w;
                    v = {6'(i2), 6'(i1), 6'(i0)};
                    exp_ira.push_back(8'(a));
                    exp_wra.push_back(8'(w));
                    exp_idx.push_back(v);
                end
        total = exp_ira.size();
        if (auto_cnt) begin
            cfg_in_cnt = max_in + 1 + $urandom_range(0, 2);
            cfg_wt_cnt = max_wt + 1 + $urandom_range(0, 2);
        end
        bus.i_loop_size = {6'(cfg_size[2]), 6'(cfg_size[1]), 6'(cfg_size[0])};
        bus.i_in_stride = {8'(cfg_is[2]), 8'(cfg_is[1]), 8'(cfg_is[0])};
        bus.i_wt_stride = {8'(cfg_ws[2]), 8'(cfg_ws[1]), 8'(cfg_ws[0])};
        bus.i_in_cnt    = 9'(cfg_in_cnt);
        bus.i_wt_cnt    = 9'(cfg_wt_cnt);
    endtask

    task automatic cfg_a();
        cfg_size = '{2, 3, 2}; cfg_is = '{1, 2, 0}; cfg_ws = '{0, 0, 1};
        cfg_in_cnt = 6; cfg_wt_cnt = 2;
        set_cfg(0);
    endtask

    // One clock: inputs already driven at the falling edge; check, then advance model.
    task automatic step();
        logic wk, act, e_in_ack, e_wt_ack, e_mrdy, in_x, wt_x, mn_x;
        logic [ADDRW-1:0] e_ira, e_wra;
        logic [NDIM*IDXW-1:0] e_idx;
        #1;
        if (rst) begin phase = P_IDLE; clr_model(); end
        wk  = (phase == P_WORK);
        act = wk || (phase == P_STALL);
        e_ira = '0; e_wra = '0; e_idx = '0;
        if (act && n_read < total) begin
            e_ira = exp_ira[n_read]; e_wra = exp_wra[n_read]; e_idx = exp_idx[n_read];
        end
        e_in_ack = wk && (n_in < cfg_in_cnt);
        e_wt_ack = wk && (n_wt < cfg_wt_cnt);
        e_mrdy   = wk && (int'(e_ira) < n_in) && (int'(e_wra) < n_wt);
        in_x = e_in_ack && bus.Input_rdy;
        wt_x = e_wt_ack && bus.Weight_rdy;
        mn_x = e_mrdy && bus.MAIN_ack;
        chk("input_ack",  bus.Input_ack,  e_in_ack);
        chk("weight_ack", bus.Weight_ack, e_wt_ack);
        chk("main_rdy",   bus.MAIN_rdy,   e_mrdy);
        chk("in_write",   bus.o_in_write, in_x);
        chk("wt_write",   bus.o_wt_write, wt_x);
        chk("read",       bus.o_read,     mn_x);
        chk("in_waddr",   bus.o_in_waddr, 8'(n_in));
        chk("wt_waddr",   bus.o_wt_waddr, 8'(n_wt));
        chk("in_raddr",   bus.o_in_raddr, e_ira);
        chk("wt_raddr",   bus.o_wt_raddr, e_wra);
        chk("idx",        bus.o_idx,      e_idx);
        chk("last",       bus.o_last,     act && (n_read == total - 1));
        chk("busy",       bus.o_busy,     (phase == P_INIT) || act);
        chk("done",       bus.o_done,     phase == P_DONE);
        if (mn_x) begin reads_seen++; last_read_cyc = cyc; end
        if (phase == P_DONE) begin dones++; done_cyc = cyc; end
        if (in_x && first_in < 0) first_in = cyc;
        if (bus.MAIN_rdy === 1'b1 && first_mrdy < 0) first_mrdy = cyc;
        @(posedge clk);
        if (rst) begin
            phase = P_IDLE; clr_model();
        end else begin
            case (phase)
                P_IDLE: if (bus.i_start) phase = P_INIT;
                P_INIT: begin clr_model(); phase = bus.i_abort ? P_IDLE : P_WORK; end
                P_WORK: begin
                    if (bus.i_abort) begin
                        phase = P_IDLE; clr_model();
                    end else begin
                        n_in += int'(in_x); n_wt += int'(wt_x); n_read += int'(mn_x);
                        if (bus.i_stall)                    phase = P_STALL;
                        else if (mn_x && n_read == total)   phase = P_DONE;
                    end
                end
                P_STALL: begin
                    if (bus.i_abort) begin phase = P_IDLE; clr_model(); end
                    else if (!bus.i_stall) phase = P_WORK;
                end
                default: phase = P_IDLE;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    // mode 0 all ready, 1 random, 2 input delayed 5 cycles, 3 stall 3 cycles, 4 abort
    task automatic run_job(input int mode, input int abort_at);
        int guard, work_cyc, stall_left;
        bit stalled_once, aborted, wk_now;
        guard = 0; work_cyc = 0; stall_left = 0; stalled_once = 0; aborted = 0;
        reads_seen = 0; dones = 0; first_in = -1; first_mrdy = -1;
        last_read_cyc = -1; done_cyc = -2; cyc = 0;
        inputs_low();
        bus.i_start = 1;
        step();
        while (phase != P_IDLE && guard < 2000) begin
            inputs_low();
            bus.Input_rdy = 1; bus.Weight_rdy = 1; bus.MAIN_ack = 1;
            case (mode)
                1: begin
                    bus.Input_rdy  = ($urandom_range(0, 3) != 0);
                    bus.Weight_rdy = ($urandom_range(0, 3) != 0);
                    bus.MAIN_ack   = ($urandom_range(0, 3) != 0);
                    bus.i_start    = ($urandom_range(0, 7) == 0);
                end
                2: bus.Input_rdy = (work_cyc >= 5);
                3: begin
                    if (!stalled_once && reads_seen >= 5 && reads_seen + 1 < total) begin
                        stalled_once = 1; stall_left = 3;
                    end
                    if (stall_left > 0) begin bus.i_stall = 1; stall_left--; end
                end
                4: if (!aborted && reads_seen >= abort_at) begin
                    bus.i_abort = 1; bus.MAIN_ack = 0; aborted = 1;
                end
                default: ;
            endcase
            wk_now = (phase == P_WORK);
            step();
            if (wk_now) work_cyc++;
            guard++;
        end
        chk("job_cycle_bound", guard < 2000, 1'b1);
        inputs_low();
    endtask

    initial begin
        rst = 1;
        inputs_low();
        cfg_a();
        phase = P_IDLE; clr_model();
        @(negedge clk);
        step();
        chk("reset_busy", bus.o_busy, 1'b0);
        chk("reset_idx",  bus.o_idx,  '0);
`ifdef PE_DPCTL_ERR_EN
        chk("reset_error", bus.o_error, 1'b0);
`endif
        rst = 0;
        step();

        cfg_a();
        run_job(0, 0);
        chk("A_reads", reads_seen, 12);
        chk("A_done_pulses", dones, 1);
        chk("A_done_latency", done_cyc, last_read_cyc + 1);

        run_job(2, 0);
        chk("B_reads", reads_seen, 12);
        chk("B_mrdy_after_first_input", first_mrdy, first_in + 1);

        run_job(3, 0);
        chk("C_reads", reads_seen, 12);
        chk("C_done_pulses", dones, 1);

        run_job(4, 4);
        chk("D_reads_before_abort", reads_seen, 4);
        chk("D_idx_cleared", bus.o_idx, '0);
        chk("D_wcnt_cleared", bus.o_in_waddr, '0);
        run_job(0, 0);
        chk("D_restart_reads", reads_seen, 12);

        cfg_size = '{2, 0, 2};
        set_cfg(0);
        run_job(0, 0);
        chk("E_zero_size_reads", reads_seen, 4);

        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 3; k++) begin
                cfg_size[k] = $urandom_range(0, 3);
                cfg_is[k]   = $urandom_range(0, 3);
                cfg_ws[k]   = $urandom_range(0, 3);
            end
            set_cfg(1);
            run_job(1, 0);
            chk("R_reads", reads_seen, total);
            chk("R_done_pulses", dones, 1);
        end

        cfg_a();
        bus.i_start = 1;
        step();
        inputs_low();
        bus.Input_rdy = 1; bus.Weight_rdy = 1; bus.MAIN_ack = 1;
        for (int i = 0; i < 6; i++) step();
        rst = 1;
        step();
        chk("async_rst_busy", bus.o_busy, 1'b0);
        chk("async_rst_idx",  bus.o_idx,  '0);
        rst = 0;
        inputs_low();
        step();
        run_job(0, 0);
        chk("after_rst_reads", reads_seen, 12);

`ifdef PE_DPCTL_ERR_EN
        cfg_a();
        inputs_low();
        bus.i_start = 1;
        step();
        bus.i_start = 0;
        step();
        chk("err_cleared_on_init", bus.o_error, 1'b0);
        bus.MAIN_ack = 1;
        step();
        bus.MAIN_ack = 0;
        chk("err_set", bus.o_error, 1'b1);
        step();
        step();
        chk("err_sticky", bus.o_error, 1'b1);
        bus.i_abort = 1;
        step();
        bus.i_abort = 0;
        step();
        chk("err_sticky_idle", bus.o_error, 1'b1);
        bus.i_start = 1;
        step();
        bus.i_start = 0;
        chk("err_clear_next_init", bus.o_error, 1'b0);
        bus.i_abort = 1;
        step();
        inputs_low();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
